// File: rtl/chaos_pkg.sv
// Shared types and widths for the chaos-based S-box key-setup stage.
package chaos_pkg;

  localparam int X_W    = 16;
  localparam int R_W    = 16;
  localparam int BYTE_W = 8;
  localparam int N_SBOX = 256;
  localparam int P_W    = 2 * X_W;
  localparam int Q_W    = P_W + R_W;

  typedef enum logic [2:0] {
    ITER_A,
    ITER_B,
    CHECK,
    FILL,
    DONE
  } state_t;

  // Candidate byte: fold both halves of the map value together.
  function automatic logic [BYTE_W-1:0] fold_byte(input logic [X_W-1:0] x);
    return x[15:8] ^ x[7:0];
  endfunction

endpackage

// File: rtl/logistic_step.sv
// One fixed-point logistic map step, split so the caller can register p between halves.
module logistic_step
  import chaos_pkg::*;
#(
  parameter logic [X_W-1:0] SEED   = 16'hA5C3,
  parameter logic [R_W-1:0] R_COEF = 16'd65372
) (
  input  logic [X_W-1:0]    i_x,
  input  logic [P_W-1:0]    i_p,
  input  logic [15:0]       i_iter,
  output logic [P_W-1:0]    o_p,
  output logic [X_W-1:0]    o_x_next,
  output logic [BYTE_W-1:0] o_c
);

  logic [X_W-1:0] w_omx;
  logic [Q_W-1:0] w_q;
  logic [X_W-1:0] w_x_raw;

  assign w_omx   = '0 - i_x;
  assign o_p     = P_W'(i_x) * P_W'(w_omx);
  assign w_q     = Q_W'(i_p) * Q_W'(R_COEF);
  // Q0.32 * Q2.14 leaves the Q0.16 result at bits [45:30].
  assign w_x_raw = X_W'(w_q >> 30);

  // Zero is a fixed point of the map; reseed from the iteration count instead.
  assign o_x_next = (w_x_raw == '0) ? ((SEED ^ i_iter) | 16'h0001) : w_x_raw;
  assign o_c      = fold_byte(o_x_next);

endmodule

// File: rtl/chaos_sbox_top.sv
// Key-setup stage: iterates the logistic map after reset and fills a bijective
// 256-entry byte S-box, falling back to an ascending fill of unused values.
module chaos_sbox_top
  import chaos_pkg::*;
#(
  parameter logic [X_W-1:0] SEED     = 16'hA5C3,
  parameter logic [R_W-1:0] R_COEF   = 16'd65372,
  parameter int             MAX_ITER = 4096
) (
  input  logic clk,
  input  logic rst,
  output logic done_sbox
);

  localparam logic [15:0] MAX_ITER_W = 16'(MAX_ITER);

  state_t                r_state;
  state_t                w_state_next;
  logic [X_W-1:0]        r_x;
  logic [P_W-1:0]        r_p;
  logic [BYTE_W-1:0]     r_c;
  logic [15:0]           r_iter;
  logic [8:0]            r_cnt;
  logic [7:0]            r_idx;
  logic [N_SBOX-1:0]     r_used;
  logic                  r_done;

  logic [BYTE_W-1:0]     sbox_mem [0:N_SBOX-1];

  logic [P_W-1:0]        w_p;
  logic [X_W-1:0]        w_x_next;
  logic [BYTE_W-1:0]     w_c;
  logic                  w_wr_en;
  logic [BYTE_W-1:0]     w_wr_val;
  logic [8:0]            w_cnt_next;

  logistic_step #(
    .SEED   (SEED),
    .R_COEF (R_COEF)
  ) u_step (
    .i_x      (r_x),
    .i_p      (r_p),
    .i_iter   (r_iter),
    .o_p      (w_p),
    .o_x_next (w_x_next),
    .o_c      (w_c)
  );

  // A value is appended only when it has not been placed before.
  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_val = r_c;
    if (r_state == CHECK) begin
      w_wr_en = !r_used[r_c];
    end else if (r_state == FILL) begin
      w_wr_en  = !r_used[r_idx];
      w_wr_val = r_idx;
    end
  end

  assign w_cnt_next = r_cnt + {8'd0, w_wr_en};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ITER_A: w_state_next = ITER_B;
      ITER_B: w_state_next = CHECK;
      CHECK: begin
        if (w_cnt_next == 9'(N_SBOX)) w_state_next = DONE;
        else if (r_iter == MAX_ITER_W) w_state_next = FILL;
        else w_state_next = ITER_A;
      end
      FILL: begin
        if (r_idx == 8'hFF) w_state_next = DONE;
      end
      DONE:    w_state_next = DONE;
      default: w_state_next = ITER_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ITER_A;
      r_x     <= SEED;
      r_p     <= '0;
      r_c     <= '0;
      r_iter  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_used  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (w_state_next == DONE);
      case (r_state)
        ITER_A: r_p <= w_p;
        ITER_B: begin
          r_x <= w_x_next;
          r_c <= w_c;
          if (r_iter != MAX_ITER_W) r_iter <= r_iter + 16'd1;
        end
        FILL:    r_idx <= r_idx + 8'd1;
        default: ;
      endcase
      if (w_wr_en) begin
        r_used[w_wr_val] <= 1'b1;
        r_cnt            <= w_cnt_next;
      end
    end
  end

  // Contents are meaningful only once done_sbox is high, so no reset here.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) sbox_mem[r_cnt[7:0]] <= w_wr_val;
  end

  assign done_sbox = r_done;

endmodule

// File: tb/tb_chaos_sbox_top.sv
// Bench for chaos_sbox_top: a plain-arithmetic model of the map and S-box build
// predicts the contents and the exact done cycle for each scenario.
module tb_chaos_sbox_top;
  import chaos_pkg::*;

  localparam logic [15:0] SEED       = 16'hA5C3;
  localparam logic [15:0] R_COEF     = 16'd65372;
  localparam int          MAX_ITER   = 4096;
  localparam int          MAX_ITER_F = 16;
  localparam int          HOLD       = 2000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_f = 1'b1;
  logic done_sbox;
  logic done_f;

  always #5 clk = ~clk;

  chaos_sbox_top #(.SEED(SEED), .R_COEF(R_COEF), .MAX_ITER(MAX_ITER)) dut (
    .clk       (clk),
    .rst       (rst),
    .done_sbox (done_sbox)
  );

  chaos_sbox_top #(.SEED(SEED), .R_COEF(R_COEF), .MAX_ITER(MAX_ITER_F)) dut_f (
    .clk       (clk),
    .rst       (rst_f),
    .done_sbox (done_f)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_sb    [256];
  logic [7:0] main_sb [256];
  logic [7:0] zero_sb [256];
  logic [7:0] fb_sb   [256];
  logic [7:0] got_sb  [256];
  logic [7:0] rec_sb  [256];
  int         m_done_cyc;
  bit         m_fell_back;
  int         d_main, d_zero, d_fb;

  function automatic logic [15:0] map_step(input logic [15:0] x, input int it, input bit zero_x);
    longint unsigned xv, omx, p, q, xn;
    xv  = zero_x ? 64'd0 : 64'(x);
    omx = (64'd65536 - xv) % 64'd65536;
    p   = xv * omx;
    q   = p * 64'(R_COEF);
    xn  = (q >> 30) % 64'd65536;
    if (xn == 0) xn = 64'((SEED ^ 16'(it)) | 16'h0001);
    return 16'(xn);
  endfunction

  // Cycle model: three clocks per map iteration, then one per fill value.
  task automatic run_model(input int max_iter, input bit zero_first);
    bit          used [256];
    int          cnt;
    logic [15:0] x;
    logic [7:0]  c;
    cnt = 0;
    x   = SEED;
    m_done_cyc  = 0;
    m_fell_back = 0;
    foreach (used[i]) used[i] = 0;
    for (int it = 0; it < max_iter && cnt < 256; it++) begin
      x = map_step(x, it, zero_first && it == 0);
      c = x[15:8] ^ x[7:0];
      if (!used[c]) begin
        used[c]  = 1;
        m_sb[cnt] = c;
        cnt++;
      end
      if (cnt == 256) m_done_cyc = 3 * (it + 1);
    end
    if (cnt < 256) begin
      m_fell_back = 1;
      for (int v = 0; v < 256; v++) begin
        if (!used[v]) begin
          m_sb[cnt] = 8'(v);
          cnt++;
        end
      end
      m_done_cyc = 3 * max_iter + 256;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  int since   = 0;
  int since_f = 0;
  int exp_d   = 1 << 30;
  int exp_d_f = 1 << 30;
  bit chk_en  = 0;
  bit saw_fill = 0;

  always @(posedge clk) begin
    since   = rst   ? 0 : since + 1;
    since_f = rst_f ? 0 : since_f + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("done_sbox_cycle", done_sbox, longint'(since >= exp_d));
      check("done_fallback_cycle", done_f, longint'(since_f >= exp_d_f));
      if (dut_f.r_state == FILL) saw_fill = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_reset(input int n, input int next_d);
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #2;
    exp_d = next_d;
    rst   = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (done_sbox !== 1'b1 && k < 3 * MAX_ITER + 260) begin
      @(negedge clk);
      k++;
    end
    check(nm, done_sbox, 1);
  endtask

  task automatic grab_main();
    for (int i = 0; i < 256; i++) got_sb[i] = dut.sbox_mem[i];
  endtask

  task automatic verify(input string nm, input int which);
    int seen [256];
    int bad_perm;
    int bad_model;
    logic [7:0] e;
    bad_perm  = 0;
    bad_model = 0;
    foreach (seen[i]) seen[i] = 0;
    for (int i = 0; i < 256; i++) seen[got_sb[i]]++;
    for (int v = 0; v < 256; v++) if (seen[v] != 1) bad_perm++;
    check({nm, "_perm_bad_values"}, bad_perm, 0);
    for (int i = 0; i < 256; i++) begin
      e = (which == 0) ? main_sb[i] : (which == 1) ? zero_sb[i] : fb_sb[i];
      if (got_sb[i] !== e) bad_model++;
    end
    check({nm, "_entries_vs_model"}, bad_model, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int diff;

    // Pin the model with hand-computed values.
    check("model_step0", map_step(SEED, 0, 0), 16'hE922);
    check("model_zero_escape", map_step(SEED, 0, 1), 16'hA5C3);
    run_model(MAX_ITER_F, 0);
    fb_sb = m_sb;
    d_fb  = m_done_cyc;
    check("model_fb_fell_back", m_fell_back, 1);
    check("model_fb_cycles", d_fb, 3 * 16 + 256);
    check("model_fb_sb0", fb_sb[0], 8'hCB);
    run_model(MAX_ITER, 1);
    zero_sb = m_sb;
    d_zero  = m_done_cyc;
    check("model_zero_sb0", zero_sb[0], 8'h66);
    run_model(MAX_ITER, 0);
    main_sb = m_sb;
    d_main  = m_done_cyc;
    check("model_main_sb0", main_sb[0], 8'hCB);

    // Scenario 1: two-cycle reset, run to completion, hold.
    rst = 1'b1; rst_f = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("done_in_reset", done_sbox, 0);
    check("done_f_in_reset", done_f, 0);
    @(posedge clk); #2;
    exp_d   = d_main;
    exp_d_f = d_fb;
    chk_en  = 1;
    rst     = 1'b0;
    rst_f   = 1'b0;
    @(negedge clk);
    check("done_after_release", done_sbox, 0);
    wait_done("s1_done_in_bound");
    repeat (HOLD) @(negedge clk);
    check("s1_done_held", done_sbox, 1);
    grab_main();
    rec_sb = got_sb;
    verify("s1_sbox", 0);
    check("s1_sbox0_literal", got_sb[0], 8'hCB);

    // Scenario 5: fallback instance ran alongside.
    check("s5_fill_entered", saw_fill, 1);
    check("s5_done_f", done_f, 1);
    for (int i = 0; i < 256; i++) got_sb[i] = dut_f.sbox_mem[i];
    verify("s5_sbox", 2);
    check("s5_sbox0_literal", got_sb[0], 8'hCB);

    // Scenario 3: one-cycle reset pulse gives the identical S-box.
    pulse_reset(1, d_main);
    @(negedge clk);
    check("s3_done_cleared", done_sbox, 0);
    wait_done("s3_done_in_bound");
    @(negedge clk);
    grab_main();
    diff = 0;
    for (int i = 0; i < 256; i++) if (got_sb[i] !== rec_sb[i]) diff++;
    check("s3_same_as_first_run", diff, 0);
    verify("s3_sbox", 0);

    // Scenario 4: reset again 500 cycles into a run.
    pulse_reset(1, d_main);
    repeat (500) @(negedge clk);
    check("s4_not_done_at_500", done_sbox, 0);
    pulse_reset(1, d_main);
    @(negedge clk);
    check("s4_done_low_after_abort", done_sbox, 0);
    wait_done("s4_done_in_bound");
    @(negedge clk);
    grab_main();
    verify("s4_sbox", 0);

    // Scenario 6: zero x on the first iteration must be escaped.
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    exp_d = d_zero;
    rst   = 1'b0;
    force dut.r_x = 16'h0000;
    @(posedge clk); #2;
    release dut.r_x;
    @(posedge clk);
    @(negedge clk);
    check("s6_x_after_escape", dut.r_x, 16'hA5C3);
    check("s6_x_nonzero", longint'(dut.r_x != 16'h0000), 1);
    wait_done("s6_done_in_bound");
    @(negedge clk);
    grab_main();
    verify("s6_sbox", 1);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
